// File: rtl/mux32_rr_sched_pkg.sv
// Shared types for the 32-way round-robin scheduler: requester count,
// index type and the output-slot state encoding.
package mux_sched_pkg;

   localparam int NREQ = 32;
   localparam int IDXW = 5;

   typedef logic [IDXW-1:0] idx_t;
   typedef logic [NREQ-1:0] reqvec_t;

   typedef enum logic {EMPTY, FULL} slot_state_t;

   function automatic reqvec_t onehot(input idx_t i);
      return reqvec_t'(1) << i;
   endfunction

endpackage

// File: rtl/mux32_rr_sched_mux.sv
// Shared 32:1 N-bit selection datapath driven by the scheduler's winner.
module mux32to1_n
   import mux_sched_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0] data_i [NREQ],
   input  idx_t         sel,
   output logic [N-1:0] data_o
);

   logic [N-1:0] masked [NREQ];

   // AND-OR tree keeps the select path balanced instead of a priority chain
   for (genvar gi = 0; gi < NREQ; gi++) begin : g_mask
      assign masked[gi] = (sel == idx_t'(gi)) ? data_i[gi] : '0;
   end

   always_comb begin
      data_o = '0;
      for (int i = 0; i < NREQ; i++) begin
         data_o = data_o | masked[i];
      end
   end

endmodule

// File: rtl/mux32_rr_sched_pick.sv
// Combinational rotate-priority finder: first set request strictly after
// ptr, wrapping around so that ptr itself is examined last.
module rr_pick32
   import mux_sched_pkg::*;
(
   input  logic [NREQ-1:0] req,
   input  idx_t            ptr,
   output logic            any,
   output idx_t            idx
);

   idx_t              start;
   logic [2*NREQ-1:0] dbl;
   logic [NREQ-1:0]   rot;
   idx_t              off;

   assign start = ptr + idx_t'(1);
   assign dbl   = {req, req};
   // rot[0] is the requester right after ptr, rot[31] is ptr itself
   assign rot   = dbl[start +: NREQ];
   assign any   = |req;

   always_comb begin
      off = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (rot[i]) begin
            off = idx_t'(i);
         end
      end
   end

   assign idx = start + off;

endmodule

// File: rtl/mux32_rr_sched.sv
// Round-robin scheduler over 32 requesters with bounded burst lock; the
// winner's word is captured into a single valid/ready output slot.
module mux32_rr_sched
   import mux_sched_pkg::*;
#(
   parameter int N         = 4,
   parameter int ADDRESS   = 5,
   parameter int MAX_BURST = 4
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [NREQ-1:0]    req_i,
   input  logic [NREQ-1:0]    lock_i,
   input  logic [N-1:0]       data_i [NREQ],
   output logic [NREQ-1:0]    gnt_o,
   output logic               valid_o,
   input  logic               ready_i,
   output logic [N-1:0]       data_o,
   output logic [ADDRESS-1:0] sel_o
);

   localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

   slot_state_t   state_q;
   logic [N-1:0]  data_q;
   idx_t          sel_q;
   idx_t          ptr_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          burst_act_q;

   logic          rr_any;
   idx_t          rr_idx;
   logic          burst_ok;
   idx_t          win;
   logic          slot_free;
   logic          cap;
   logic [N-1:0]  mux_out;

   rr_pick32 u_pick (
      .req (req_i),
      .ptr (ptr_q),
      .any (rr_any),
      .idx (rr_idx)
   );

   mux32to1_n #(.N(N)) u_mux (
      .data_i (data_i),
      .sel    (win),
      .data_o (mux_out)
   );

   // The owner keeps the slot only while it still requests, still holds
   // its lock, and has not yet used up its burst allowance.
   assign burst_ok  = burst_act_q && req_i[ptr_q] && lock_i[ptr_q] && (cnt_q < CNT_LAST);
   assign win       = burst_ok ? ptr_q : rr_idx;
   assign slot_free = (state_q == EMPTY) || ready_i;
   assign cap       = rr_any && slot_free;
   assign cnt_d     = burst_ok ? (cnt_q + CW'(1)) : '0;

   assign gnt_o = (cap && !rst_i) ? onehot(win) : '0;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= EMPTY;
         data_q      <= '0;
         sel_q       <= '0;
         ptr_q       <= idx_t'(NREQ - 1);
         cnt_q       <= '0;
         burst_act_q <= 1'b0;
      end else begin
         case (state_q)
            EMPTY: begin
               if (cap) begin
                  state_q <= FULL;
               end
            end
            FULL: begin
               if (ready_i && !cap) begin
                  state_q <= EMPTY;
               end
            end
            default: state_q <= EMPTY;
         endcase
         if (cap) begin
            data_q      <= mux_out;
            sel_q       <= win;
            ptr_q       <= win;
            cnt_q       <= cnt_d;
            burst_act_q <= lock_i[win];
         end
      end
   end

   assign valid_o = (state_q == FULL);
   assign data_o  = data_q;
   assign sel_o   = sel_q;

endmodule

// File: tb/tb_mux32_rr_sched.sv
// Self-checking bench for mux32_rr_sched: directed scenarios plus a random
// run against a behavioural scheduler model.
module tb_mux32_rr_sched;

   localparam int N    = 4;
   localparam int MAXB = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          ready;
   logic [31:0]   req;
   logic [31:0]   lock;
   logic [N-1:0]  din [32];
   logic [31:0]   gnt;
   logic          valid;
   logic [N-1:0]  dout;
   logic [4:0]    sel;

   int checks = 0;
   int errors = 0;

   // behavioural model state
   bit m_valid;
   int m_data;
   int m_sel;
   int m_ptr;
   int m_run;
   bit m_burst;

   always #5 clk = ~clk;

   mux32_rr_sched #(.N(N), .ADDRESS(5), .MAX_BURST(MAXB)) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .req_i   (req),
      .lock_i  (lock),
      .data_i  (din),
      .gnt_o   (gnt),
      .valid_o (valid),
      .ready_i (ready),
      .data_o  (dout),
      .sel_o   (sel)
   );

   // Winner by the scheduling rules: the locked owner may continue while its
   // run is shorter than MAXB, otherwise scan forward from the last winner.
   function automatic int pick(output bit cap, output bit sticky);
      int w;
      w = -1;
      sticky = 1'b0;
      if (m_burst && req[m_ptr] && lock[m_ptr] && (m_run < MAXB)) begin
         w = m_ptr;
         sticky = 1'b1;
      end else begin
         for (int i = 1; i <= 32; i++) begin
            if (w < 0 && req[(m_ptr + i) % 32]) w = (m_ptr + i) % 32;
         end
      end
      cap = (w >= 0) && (!m_valid || ready) && !rst;
      return w;
   endfunction

   function automatic logic [31:0] exp_gnt();
      bit c;
      bit s;
      int w;
      w = pick(c, s);
      return c ? (32'd1 << w) : 32'd0;
   endfunction

   task automatic model_reset();
      m_valid = 0;
      m_data  = 0;
      m_sel   = 0;
      m_ptr   = 31;
      m_run   = 0;
      m_burst = 0;
   endtask

   task automatic commit();
      bit c;
      bit s;
      int w;
      if (rst) begin
         model_reset();
      end else begin
         w = pick(c, s);
         if (c) begin
            m_data  = int'(din[w]);
            m_sel   = w;
            m_valid = 1;
            m_run   = s ? m_run + 1 : 1;
            m_ptr   = w;
            m_burst = lock[w];
         end else if (m_valid && ready) begin
            m_valid = 0;
         end
      end
   endtask

   task automatic tick();
      $display("[%0t] req=%h lock=%h rdy=%0b rst=%0b gnt=%h valid=%0b sel=%0d data=%h",
               $time, req, lock, ready, rst, gnt, valid, sel, dout);
      @(posedge clk);
      commit();
      #1;
      for (int i = 0; i < 32; i++) din[i] = N'($urandom);
   endtask

   task automatic apply_reset();
      rst = 1; req = 0; lock = 0; ready = 1;
      @(negedge clk);
      tick();
      rst = 0;
   endtask

   task automatic test_reset();
      rst = 1; req = $urandom; lock = $urandom; ready = 1;
      repeat (2) begin
         @(negedge clk);
         checks++;
         if (gnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_gnt got=%h exp=0", gnt);
         end
         tick();
      end
      rst = 0; req = 0;
      @(negedge clk);
      checks++;
      if (valid !== 1'b0 || sel !== 5'd0 || gnt !== 32'd0) begin
         errors++;
         $display("FAIL reset_idle got valid=%0b sel=%0d gnt=%h exp 0/0/0", valid, sel, gnt);
      end
      tick();
   endtask

   task automatic test_priority();
      int exp_seq [4];
      int prev_w;
      logic [N-1:0] prev_word;
      exp_seq = '{0, 31, 0, 31};
      apply_reset();
      req = 32'h8000_0001; ready = 1;
      prev_w = 0; prev_word = '0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (gnt !== (32'd1 << exp_seq[i])) begin
            errors++;
            $display("FAIL prio_gnt step=%0d got=%h exp=%h", i, gnt, 32'd1 << exp_seq[i]);
         end
         if (i > 0) begin
            checks++;
            if (sel !== 5'(prev_w) || dout !== prev_word || valid !== 1'b1) begin
               errors++;
               $display("FAIL prio_lag step=%0d got sel=%0d data=%h exp sel=%0d data=%h",
                        i, sel, dout, prev_w, prev_word);
            end
         end
         prev_w = exp_seq[i];
         prev_word = din[exp_seq[i]];
         tick();
      end
   endtask

   task automatic test_rotation();
      apply_reset();
      req = 32'hFFFF_FFFF; ready = 1;
      for (int i = 0; i < 33; i++) begin
         @(negedge clk);
         checks++;
         if (gnt !== (32'd1 << (i % 32))) begin
            errors++;
            $display("FAIL rotate_gnt step=%0d got=%h exp=%h", i, gnt, 32'd1 << (i % 32));
         end
         if (i > 0) begin
            checks++;
            if (valid !== 1'b1) begin
               errors++;
               $display("FAIL rotate_bubble step=%0d got valid=%0b exp=1", i, valid);
            end
         end
         tick();
      end
   endtask

   task automatic test_back_pressure();
      logic [N-1:0] word5;
      apply_reset();
      req = 32'd1 << 5; ready = 1;
      @(negedge clk);
      checks++;
      if (gnt !== (32'd1 << 5)) begin
         errors++;
         $display("FAIL bp_first got=%h exp=%h", gnt, 32'd1 << 5);
      end
      word5 = din[5];
      tick();
      ready = 0;
      repeat (3) begin
         req = $urandom | 32'h1;
         @(negedge clk);
         checks++;
         if (gnt !== 32'd0 || sel !== 5'd5 || dout !== word5 || valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold got gnt=%h sel=%0d data=%h valid=%0b exp 0/5/%h/1",
                     gnt, sel, dout, valid, word5);
         end
         tick();
      end
      ready = 1; req = 32'hFFFF_FFFF;
      @(negedge clk);
      checks++;
      if (gnt !== (32'd1 << 6)) begin
         errors++;
         $display("FAIL bp_resume got=%h exp=%h", gnt, 32'd1 << 6);
      end
      tick();
      req = 0;
      @(negedge clk);
      checks++;
      if (sel !== 5'd6 || valid !== 1'b1) begin
         errors++;
         $display("FAIL bp_after got sel=%0d valid=%0b exp 6/1", sel, valid);
      end
      tick();
   endtask

   task automatic test_burst();
      int locked [10];
      int free [4];
      locked = '{2, 2, 2, 2, 9, 2, 2, 2, 2, 9};
      free   = '{2, 9, 2, 9};
      apply_reset();
      req = (32'd1 << 2) | (32'd1 << 9); lock = 32'd1 << 2; ready = 1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if (gnt !== (32'd1 << locked[i])) begin
            errors++;
            $display("FAIL burst_lock step=%0d got=%h exp=%h", i, gnt, 32'd1 << locked[i]);
         end
         tick();
      end
      apply_reset();
      req = (32'd1 << 2) | (32'd1 << 9); lock = 0; ready = 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (gnt !== (32'd1 << free[i])) begin
            errors++;
            $display("FAIL burst_nolock step=%0d got=%h exp=%h", i, gnt, 32'd1 << free[i]);
         end
         tick();
      end
   endtask

   task automatic test_reset_midburst();
      int lowest;
      apply_reset();
      req = (32'd1 << 2) | (32'd1 << 9); lock = 32'd1 << 2; ready = 1;
      repeat (3) begin
         @(negedge clk);
         tick();
      end
      rst = 1;
      @(negedge clk);
      checks++;
      if (gnt !== 32'd0) begin
         errors++;
         $display("FAIL midrst_gnt got=%h exp=0", gnt);
      end
      tick();
      rst = 0;
      req = $urandom & ~32'h7;
      if (req == 0) req = 32'h100;
      lowest = -1;
      for (int i = 31; i >= 0; i--) if (req[i]) lowest = i;
      @(negedge clk);
      checks++;
      if (valid !== 1'b0 || gnt !== (32'd1 << lowest)) begin
         errors++;
         $display("FAIL midrst_after got valid=%0b gnt=%h exp 0/%h", valid, gnt, 32'd1 << lowest);
      end
      tick();
   endtask

   task automatic test_random();
      logic [31:0] eg;
      apply_reset();
      for (int c = 0; c < 600; c++) begin
         rst   = ($urandom_range(0, 59) == 0);
         ready = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 3))
            0: req = 0;
            1: req = $urandom;
            default: req = $urandom & $urandom & $urandom;
         endcase
         lock = $urandom | $urandom;
         @(negedge clk);
         eg = exp_gnt();
         checks++;
         if (gnt !== eg) begin
            errors++;
            $display("FAIL rand_gnt cyc=%0d got=%h exp=%h", c, gnt, eg);
         end
         checks++;
         if (valid !== m_valid || sel !== 5'(m_sel) || dout !== N'(m_data)) begin
            errors++;
            $display("FAIL rand_slot cyc=%0d got valid=%0b sel=%0d data=%h exp %0b/%0d/%h",
                     c, valid, sel, dout, m_valid, m_sel, N'(m_data));
         end
         tick();
      end
   endtask

   initial begin
      rst = 1; req = 0; lock = 0; ready = 1;
      for (int i = 0; i < 32; i++) din[i] = N'($urandom);
      model_reset();
      test_reset();
      test_priority();
      test_rotation();
      test_back_pressure();
      test_burst();
      test_reset_midburst();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
